// File: rtl/rx_checksum_arb_pkg.sv
// Shared definitions for the rx_* checksum blocks: arbiter states and limits.
package rx_checksum_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int unsigned PORTS_MAX  = 16;
    localparam int unsigned CSUM_WIDTH = 16;

endpackage

// File: rtl/rx_checksum_arb_fifo.sv
// Synchronous FIFO with first-word fall-through; pointers carry one extra
// wrap bit so full/empty are distinguished without a separate count.
module rx_checksum_arb_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (wr_en && !full) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointer update, wrapping naturally at 2*DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (rd_en && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/rx_checksum_arb.sv
// Round-robin arbiter sharing one checksum engine between PORTS RX streams.
// Frames are granted whole, tagged with their source, and engine results are
// re-joined with their tag in grant order. A credit counter caps frames in
// flight at DEPTH so the unstallable engine output always finds room.
module rx_checksum_arb
    import rx_checksum_arb_pkg::*;
#(
    parameter int unsigned PORTS      = 4,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned TAG_WIDTH  = $clog2(PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [PORTS*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [PORTS-1:0]            s_axis_tvalid,
    input  logic [PORTS-1:0]            s_axis_tlast,
    output logic [PORTS-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]       m_eng_tdata,
    output logic [KEEP_WIDTH-1:0]       m_eng_tkeep,
    output logic                        m_eng_tvalid,
    output logic                        m_eng_tlast,
    input  logic [15:0]                 s_eng_csum,
    input  logic                        s_eng_csum_valid,
    output logic [15:0]                 m_axis_csum,
    output logic [TAG_WIDTH-1:0]        m_axis_csum_tag,
    output logic                        m_axis_csum_valid,
    input  logic                        m_axis_csum_ready,
    output logic                        busy,
    output logic                        err_orphan
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned RW = TAG_WIDTH + CSUM_WIDTH;

    arb_state_t             state_q, state_d;
    logic [TAG_WIDTH-1:0]   grant_q, grant_d;
    logic [TAG_WIDTH-1:0]   rr_ptr, rr_d;
    logic [TAG_WIDTH-1:0]   pick;
    logic [TAG_WIDTH:0]     idx;
    logic                   pick_valid;
    logic                   grant_fire;
    logic                   beat_acc;
    logic [CW-1:0]          credits;
    logic [DATA_WIDTH-1:0]  eng_data_d;
    logic [KEEP_WIDTH-1:0]  eng_keep_d;
    logic                   eng_last_d;

    logic [TAG_WIDTH-1:0]   tag_head;
    logic                   tag_empty;
    logic                   tag_pop;
    logic [RW-1:0]          res_head;
    logic                   res_empty;
    logic                   res_pop;
    logic [RW-1:0]          last_q;

    assign busy              = (state_q == GRANT);
    assign tag_pop           = s_eng_csum_valid && !tag_empty;
    assign m_axis_csum_valid = !res_empty;
    assign res_pop           = m_axis_csum_valid && m_axis_csum_ready;
    // Once drained, the outputs keep showing the last delivered entry.
    assign {m_axis_csum_tag, m_axis_csum} = res_empty ? last_q : res_head;

    // First requesting port at or after rr_ptr, wrapping modulo PORTS.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        idx        = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            idx = {1'b0, rr_ptr} + (TAG_WIDTH+1)'(i);
            if (idx >= (TAG_WIDTH+1)'(PORTS)) begin
                idx = idx - (TAG_WIDTH+1)'(PORTS);
            end
            if (!pick_valid && s_axis_tvalid[idx[TAG_WIDTH-1:0]]) begin
                pick_valid = 1'b1;
                pick       = idx[TAG_WIDTH-1:0];
            end
        end
    end

    // Next-state, grant and tready decode.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_d          = rr_ptr;
        grant_fire    = 1'b0;
        beat_acc      = 1'b0;
        s_axis_tready = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid && (credits < CW'(DEPTH))) begin
                    grant_fire = 1'b1;
                    grant_d    = pick;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                s_axis_tready[grant_q] = 1'b1;
                beat_acc               = s_axis_tvalid[grant_q];
                if (beat_acc && s_axis_tlast[grant_q]) begin
                    rr_d    = (grant_q == TAG_WIDTH'(PORTS-1)) ? '0 : grant_q + TAG_WIDTH'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Select the granted port's beat for the engine register stage.
    always_comb begin
        eng_data_d = '0;
        eng_keep_d = '0;
        eng_last_d = 1'b0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            if (grant_q == TAG_WIDTH'(i)) begin
                eng_data_d = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                eng_keep_d = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                eng_last_d = s_axis_tlast[i];
            end
        end
    end

    // Arbiter state, grant and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_ptr  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_ptr  <= rr_d;
        end
    end

    // One register stage toward the engine; valid pulses per accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_eng_tvalid <= 1'b0;
            m_eng_tdata  <= '0;
            m_eng_tkeep  <= '0;
            m_eng_tlast  <= 1'b0;
        end else begin
            m_eng_tvalid <= beat_acc;
            if (beat_acc) begin
                m_eng_tdata <= eng_data_d;
                m_eng_tkeep <= eng_keep_d;
                m_eng_tlast <= eng_last_d;
            end
        end
    end

    // Credits: +1 per grant, -1 per delivered result, unchanged when both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits <= '0;
        end else begin
            case ({grant_fire, res_pop})
                2'b10:   credits <= credits + CW'(1);
                2'b01:   credits <= credits - CW'(1);
                default: credits <= credits;
            endcase
        end
    end

    // Sticky orphan flag and hold register for the last delivered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_orphan <= 1'b0;
            last_q     <= '0;
        end else begin
            if (s_eng_csum_valid && tag_empty) begin
                err_orphan <= 1'b1;
            end
            if (res_pop) begin
                last_q <= res_head;
            end
        end
    end

    rx_checksum_arb_fifo #(
        .WIDTH (TAG_WIDTH),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (grant_fire),
        .wr_data (pick),
        .rd_en   (tag_pop),
        .rd_data (tag_head),
        .empty   (tag_empty)
    );

    rx_checksum_arb_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (tag_pop),
        .wr_data ({tag_head, s_eng_csum}),
        .rd_en   (res_pop),
        .rd_data (res_head),
        .empty   (res_empty)
    );

endmodule
